// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : ROM read port, decode handshake and redirect bundle for the fetch unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        misalign_err;

  // Fetch-unit side
  modport master (
    output rom_addr,
    input  rom_dout,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_fault,
    output misalign_err
  );

  // Environment side: ROM, decoder and execute
  modport slave (
    input  rom_addr,
    output rom_dout,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_fault,
    input  misalign_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Fetch PC, combinational ROM read and 2-entry instruction queue to decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] ROM_BASE  = 32'hBFC00000,
  parameter int unsigned ROM_WORDS = 4096
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  instr_fetch_if.master bus
);

  localparam logic [32:0] c_ROM_END = {1'b0, ROM_BASE} + (33'(ROM_WORDS) << 2);
  localparam logic [31:0] c_NOP     = 32'h00000013;

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_count;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];
  logic        r_q_fault [2];
  logic        r_misalign;

  logic [31:0] w_rom_addr;
  logic        w_fault;
  logic [31:0] w_new_instr;
  logic        w_pop;
  logic        w_enq;
  logic [1:0]  w_cnt_after_pop;

  always_comb begin
    w_rom_addr = r_fetch_pc;
    if (bus.redirect_valid) begin
      w_rom_addr = {bus.redirect_target[31:2], 2'b00};
    end
    // 33-bit compare so a window ending at 2^32 does not wrap
    w_fault         = (w_rom_addr < ROM_BASE) || ({1'b0, w_rom_addr} >= c_ROM_END);
    w_new_instr     = w_fault ? c_NOP : bus.rom_dout;
    w_pop           = (r_count != 2'd0) && bus.out_ready && !bus.redirect_valid;
    w_enq           = bus.redirect_valid || (r_count < 2'd2) || w_pop;
    w_cnt_after_pop = r_count - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_count      <= 2'd0;
      r_misalign   <= 1'b0;
      r_q_instr[0] <= 32'd0;
      r_q_instr[1] <= 32'd0;
      r_q_pc[0]    <= 32'd0;
      r_q_pc[1]    <= 32'd0;
      r_q_fault[0] <= 1'b0;
      r_q_fault[1] <= 1'b0;
    end else begin
      r_misalign <= bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
      if (w_enq) begin
        r_fetch_pc <= w_rom_addr + 32'd4;
      end
      if (bus.redirect_valid) begin
        r_count      <= 2'd1;
        r_q_instr[0] <= w_new_instr;
        r_q_pc[0]    <= w_rom_addr;
        r_q_fault[0] <= w_fault;
      end else begin
        if (w_pop) begin
          r_q_instr[0] <= r_q_instr[1];
          r_q_pc[0]    <= r_q_pc[1];
          r_q_fault[0] <= r_q_fault[1];
        end
        // New entry lands behind whatever survives the pop; written last so it wins the shift
        if (w_enq) begin
          r_q_instr[w_cnt_after_pop[0]] <= w_new_instr;
          r_q_pc[w_cnt_after_pop[0]]    <= w_rom_addr;
          r_q_fault[w_cnt_after_pop[0]] <= w_fault;
        end
        r_count <= w_cnt_after_pop + {1'b0, w_enq};
      end
    end
  end

  assign bus.rom_addr     = w_rom_addr;
  assign bus.out_valid    = (r_count != 2'd0);
  assign bus.out_instr    = r_q_instr[0];
  assign bus.out_pc       = r_q_pc[0];
  assign bus.out_fault    = r_q_fault[0];
  assign bus.misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a combinational ROM model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] c_RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] c_ROM_BASE  = 32'hBFC00000;
  localparam int unsigned c_ROM_WORDS = 4096;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_mis;
  logic exp_mis;
  exp_t exp_q[$];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (c_RESET_PC),
    .ROM_BASE  (c_ROM_BASE),
    .ROM_WORDS (c_ROM_WORDS)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_window(input logic [31:0] a);
    longint unsigned lo;
    longint unsigned hi;
    lo = longint'(c_ROM_BASE);
    hi = lo + 4 * longint'(c_ROM_WORDS);
    return (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    if (!in_window(a)) return 32'hDEAD0000 | {16'd0, a[15:0]};
    idx = (a - c_ROM_BASE) >> 2;
    if (idx < 4) return (idx + 32'd1) * 32'h11;
    return 32'h5A000000 | idx;
  endfunction

  always_comb bus.rom_dout = rom_word(bus.rom_addr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.fault = !in_window(e.pc);
      e.instr = e.fault ? 32'h00000013 : rom_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs and score any handshake that will complete on the next edge
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] tgt);
    exp_t e;
    check_val("misalign", 32'(bus.misalign_err), 32'(exp_mis));
    bus.out_ready       = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    #2;
    if (rv) check_val("rom_addr_redir", bus.rom_addr, {tgt[31:2], 2'b00});
    if (bus.out_valid && rdy && !rv) begin
      if (exp_q.size() == 0) begin
        check_val("sb_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("out_pc", bus.out_pc, e.pc);
        check_val("out_instr", bus.out_instr, e.instr);
        check_val("out_fault", 32'(bus.out_fault), 32'(e.fault));
      end
    end
    if (rv) push_stream({tgt[31:2], 2'b00}, 8);
    exp_mis = rv && (tgt[1:0] != 2'b00);
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    tick();
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_fault", 32'(bus.out_fault), 32'd0);
    check_val("rst_mis", 32'(bus.misalign_err), 32'd0);
    check_val("rst_instr", bus.out_instr, 32'd0);
    check_val("rst_pc", bus.out_pc, 32'd0);
    rst_n   = 1'b1;
    exp_mis = 1'b0;
    push_stream(c_RESET_PC, 16);
  endtask

  initial begin
    n_vec               = 0;
    n_mis               = 0;
    exp_mis             = 1'b0;
    rst_n               = 1'b0;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    tick();

    // Streaming after reset
    do_reset();
    drive(1'b1, 1'b0, 32'd0);
    check_val("first_addr", bus.rom_addr, c_RESET_PC);
    check_val("first_valid", 32'(bus.out_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      check_val("stream_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end

    // Backpressure: queue saturates, fetch address holds
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      if (i >= 2) begin
        check_val("bp_addr", bus.rom_addr, 32'hBFC00008);
        check_val("bp_head", bus.out_pc, 32'hBFC00000);
        check_val("bp_valid", 32'(bus.out_valid), 32'd1);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      check_val("drain_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end

    // Redirect with a full queue
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 32'hBFC00100);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      check_val("redir_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end

    // Misaligned redirect
    drive(1'b1, 1'b1, 32'hBFC00102);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      tick();
    end

    // Out-of-window redirect, then back
    drive(1'b1, 1'b1, 32'h00000000);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      check_val("oow_fault", 32'(bus.out_fault), 32'd1);
      check_val("oow_nop", bus.out_instr, 32'h00000013);
      tick();
    end
    drive(1'b1, 1'b1, 32'hBFC00000);
    tick();
    drive(1'b1, 1'b0, 32'd0);
    check_val("back_fault", 32'(bus.out_fault), 32'd0);
    tick();

    // PC wrap past 2^32
    drive(1'b1, 1'b1, 32'hFFFFFFFC);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      check_val("wrap_fault", 32'(bus.out_fault), 32'd1);
      tick();
    end

    // Reset mid-stream with a full queue
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      tick();
    end
    do_reset();
    drive(1'b1, 1'b0, 32'd0);
    check_val("rel_addr", bus.rom_addr, c_RESET_PC);
    check_val("rel_valid0", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'd0);
    check_val("rel_valid1", 32'(bus.out_valid), 32'd1);
    check_val("rel_pc", bus.out_pc, c_RESET_PC);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
